// File: rtl/dmux8way_pkg.sv
// ============================================================================
// Module   : dmux8way_pkg
// Brief    : Shared constants, state encoding and sel-stepping helper for the
//            dmux8way serial driver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmux8way_pkg;

    localparam int N_SAIDAS = 8;
    localparam int SEL_W    = 3;

    // 2'b11 is not a legal code; the FSM falls back to IDLE from it.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    function automatic logic [SEL_W-1:0] next_sel(
        input logic [SEL_W-1:0] cur,
        input logic             msb_first
    );
        next_sel = msb_first ? (cur - 1'b1) : (cur + 1'b1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmux8way_seq_if.sv
// ============================================================================
// Module   : dmux8way_seq_if
// Brief    : Word handshake plus serial (entrada, sel) bus of dmux8way_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmux8way_seq_if;
    import dmux8way_pkg::*;

    logic [N_SAIDAS-1:0] dado;
    logic                valid;
    logic                ready;
    logic                entrada;
    logic [SEL_W-1:0]    sel;
    logic                busy;
    logic                done;

    modport master (
        output dado, valid,
        input  ready, entrada, sel, busy, done
    );

    modport slave (
        input  dado, valid,
        output ready, entrada, sel, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/contador_hold.sv
// ============================================================================
// Module   : contador_hold
// Brief    : Hold timer; tc pulses on the last of every HOLD_CYCLES enabled
//            cycles, and the count restarts from zero after each pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module contador_hold #(
    parameter int HOLD_CYCLES = 1
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic en,
    output logic      tc
);

    localparam int               CNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tc    = en && (cnt_q == CNT_LAST);
        cnt_d = '0;
        if (en && !tc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmux8way_seq.sv
// ============================================================================
// Module   : dmux8way_seq
// Brief    : Serialises one handshaken 8-bit word onto (entrada, sel) for a
//            downstream dmux8way, then pulses done for one cycle.
//            Build option: DMUX8WAY_SEQ_MSB_FIRST_EN walks sel 7..0 instead
//            of 0..7.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmux8way_seq
    import dmux8way_pkg::*;
#(
    parameter int HOLD_CYCLES = 1
) (
    input  wire logic     clock,
    input  wire logic     reset,
    dmux8way_seq_if.slave bus
);

    generate
        if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
            $error("dmux8way_seq: HOLD_CYCLES must be within 1..255");
        end
    endgenerate

`ifdef DMUX8WAY_SEQ_MSB_FIRST_EN
    localparam logic MSB_FIRST = 1'b1;
`else
    localparam logic MSB_FIRST = 1'b0;
`endif

    localparam logic [SEL_W-1:0] SEL_FIRST = MSB_FIRST ? SEL_W'(N_SAIDAS - 1) : '0;
    localparam logic [SEL_W-1:0] SEL_LAST  = MSB_FIRST ? '0 : SEL_W'(N_SAIDAS - 1);
    // The shift register moves toward the tapped end, so the tap always holds dado[sel].
    localparam int               TAP_BIT   = MSB_FIRST ? (N_SAIDAS - 1) : 0;

    state_t              state_q;
    state_t              state_d;
    logic [SEL_W-1:0]    sel_q;
    logic [SEL_W-1:0]    sel_d;
    logic [N_SAIDAS-1:0] shreg_q;
    logic [N_SAIDAS-1:0] shreg_d;
    logic                hold_en;
    logic                hold_tc;

    contador_hold #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_contador_hold (
        .clock (clock),
        .reset (reset),
        .en    (hold_en),
        .tc    (hold_tc)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        shreg_d = shreg_q;
        hold_en = 1'b0;
        case (state_q)
            IDLE: begin
                sel_d = '0;
                if (bus.valid) begin
                    shreg_d = bus.dado;
                    sel_d   = SEL_FIRST;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                hold_en = 1'b1;
                if (hold_tc) begin
                    if (sel_q == SEL_LAST) begin
                        sel_d   = '0;
                        shreg_d = '0;
                        state_d = DONE;
                    end else begin
                        sel_d   = next_sel(sel_q, MSB_FIRST);
                        shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                    end
                end
            end
            DONE: begin
                sel_d   = '0;
                state_d = IDLE;
            end
            default: begin
                sel_d   = '0;
                shreg_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            shreg_q <= shreg_d;
        end
    end

    assign bus.ready   = (state_q == IDLE);
    assign bus.busy    = (state_q == SHIFT) || (state_q == DONE);
    assign bus.done    = (state_q == DONE);
    assign bus.sel     = sel_q;
    assign bus.entrada = (state_q == SHIFT) && shreg_q[TAP_BIT];

endmodule

`default_nettype wire

// File: tb/tb_dmux8way_seq.sv
// ============================================================================
// Module   : tb_dmux8way_seq
// Brief    : Directed bench for dmux8way_seq at HOLD_CYCLES=1 and 3, with a
//            behavioural dmux8way downstream of the HOLD_CYCLES=1 instance.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmux8way_seq;

    logic clock;
    logic reset;
    int   n_vec;
    int   n_err;

    dmux8way_seq_if if1 ();
    dmux8way_seq_if if3 ();

    dmux8way_seq #(.HOLD_CYCLES(1)) u_dut1 (.clock(clock), .reset(reset), .bus(if1));
    dmux8way_seq #(.HOLD_CYCLES(3)) u_dut3 (.clock(clock), .reset(reset), .bus(if3));

    // Downstream dmux8way: outs[i] (a..h) carries entrada when sel == i.
    logic [7:0] outs1;
    assign outs1 = if1.entrada ? (8'b1 << if1.sel) : 8'h00;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [2:0] exp_sel(input int k);
`ifdef DMUX8WAY_SEQ_MSB_FIRST_EN
        exp_sel = 3'(7 - k);
`else
        exp_sel = 3'(k);
`endif
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        if1.valid = 1'b0; if1.dado = 8'h00;
        if3.valid = 1'b0; if3.dado = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if ({if1.ready, if1.busy, if1.done, if1.sel, if1.entrada} !== 7'b1_0_0_000_0) begin
                n_err++;
                $display("FAIL reset_idle1 cyc=%0d got %b want 1000000", i,
                         {if1.ready, if1.busy, if1.done, if1.sel, if1.entrada});
            end
            n_vec++;
            if ({if3.ready, if3.busy, if3.done, if3.sel, if3.entrada} !== 7'b1_0_0_000_0) begin
                n_err++;
                $display("FAIL reset_idle3 cyc=%0d got %b want 1000000", i,
                         {if3.ready, if3.busy, if3.done, if3.sel, if3.entrada});
            end
            tick();
        end
    endtask

    task automatic test_reset_and_valid();
        reset = 1'b1; if1.valid = 1'b1; if1.dado = 8'hFF;
        tick();
        reset = 1'b0; if1.valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if ({if1.ready, if1.busy, if1.done} !== 3'b100) begin
                n_err++;
                $display("FAIL reset_wins cyc=%0d got %b want 100", i, {if1.ready, if1.busy, if1.done});
            end
            tick();
        end
    endtask

    task automatic test_basic();
        logic [7:0] word;
        int         cnt [8];
        word = 8'b1010_0101;
        for (int j = 0; j < 8; j++) cnt[j] = 0;
        if1.dado = word; if1.valid = 1'b1;
        tick();
        if1.valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_vec++;
            if ({if1.sel, if1.entrada, if1.ready, if1.busy, if1.done} !== {exp_sel(k), word[exp_sel(k)], 3'b010}) begin
                n_err++;
                $display("FAIL basic_step k=%0d got sel=%0d ent=%b rbd=%b want sel=%0d ent=%b rbd=010",
                         k, if1.sel, if1.entrada, {if1.ready, if1.busy, if1.done}, exp_sel(k), word[exp_sel(k)]);
            end
            for (int j = 0; j < 8; j++) cnt[j] += int'(outs1[j]);
            tick();
        end
        n_vec++;
        if ({if1.ready, if1.busy, if1.done, if1.sel, if1.entrada} !== 7'b0_1_1_000_0) begin
            n_err++;
            $display("FAIL basic_done got %b want 0110000", {if1.ready, if1.busy, if1.done, if1.sel, if1.entrada});
        end
        tick();
        n_vec++;
        if ({if1.ready, if1.busy, if1.done} !== 3'b100) begin
            n_err++;
            $display("FAIL basic_ready_back got %b want 100", {if1.ready, if1.busy, if1.done});
        end
        for (int j = 0; j < 8; j++) begin
            n_vec++;
            if (cnt[j] !== int'(word[j])) begin
                n_err++;
                $display("FAIL basic_pulse ch=%0d got %0d cycles want %0d", j, cnt[j], word[j]);
            end
        end
    endtask

    task automatic test_hold_stretch();
        if3.dado = 8'hFF; if3.valid = 1'b1;
        tick();
        if3.valid = 1'b0;
        for (int c = 0; c < 24; c++) begin
            n_vec++;
            if ({if3.sel, if3.entrada, if3.busy, if3.done} !== {exp_sel(c / 3), 3'b110}) begin
                n_err++;
                $display("FAIL hold_step c=%0d got sel=%0d ent=%b busy=%b done=%b want sel=%0d ent=1 busy=1 done=0",
                         c, if3.sel, if3.entrada, if3.busy, if3.done, exp_sel(c / 3));
            end
            tick();
        end
        n_vec++;
        if ({if3.done, if3.sel, if3.entrada} !== 5'b1_000_0) begin
            n_err++;
            $display("FAIL hold_done25 got %b want 10000", {if3.done, if3.sel, if3.entrada});
        end
        tick();
        n_vec++;
        if ({if3.ready, if3.busy, if3.done} !== 3'b100) begin
            n_err++;
            $display("FAIL hold_ready_back got %b want 100", {if3.ready, if3.busy, if3.done});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w1;
        logic [7:0] w2;
        w1 = 8'h01;
        w2 = 8'h80;
        if1.dado = w1; if1.valid = 1'b1;
        tick();
        if1.dado = w2;
        for (int k = 0; k < 8; k++) begin
            n_vec++;
            if ({if1.sel, if1.entrada} !== {exp_sel(k), w1[exp_sel(k)]}) begin
                n_err++;
                $display("FAIL b2b_w1 k=%0d got sel=%0d ent=%b want sel=%0d ent=%b",
                         k, if1.sel, if1.entrada, exp_sel(k), w1[exp_sel(k)]);
            end
            tick();
        end
        n_vec++;
        if ({if1.done, if1.ready} !== 2'b10) begin
            n_err++;
            $display("FAIL b2b_done1 got done,ready=%b want 10", {if1.done, if1.ready});
        end
        tick();
        n_vec++;
        if ({if1.ready, if1.busy} !== 2'b10) begin
            n_err++;
            $display("FAIL b2b_ready_at10 got ready,busy=%b want 10", {if1.ready, if1.busy});
        end
        tick();
        if1.dado = 8'hFF; if1.valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_vec++;
            if ({if1.sel, if1.entrada, if1.busy} !== {exp_sel(k), w2[exp_sel(k)], 1'b1}) begin
                n_err++;
                $display("FAIL b2b_w2 k=%0d got sel=%0d ent=%b busy=%b want sel=%0d ent=%b busy=1",
                         k, if1.sel, if1.entrada, if1.busy, exp_sel(k), w2[exp_sel(k)]);
            end
            tick();
        end
        n_vec++;
        if (if1.done !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_done2 got %b want 1", if1.done);
        end
        tick();
        n_vec++;
        if ({if1.ready, if1.busy, if1.done} !== 3'b100) begin
            n_err++;
            $display("FAIL b2b_idle got %b want 100", {if1.ready, if1.busy, if1.done});
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] w;
        int         k;
        if1.dado = 8'hFF; if1.valid = 1'b1;
        tick();
        if1.valid = 1'b0;
        k = 0;
        while (exp_sel(k) != 3'd4 && k < 8) begin
            tick();
            k++;
        end
        n_vec++;
        if ({if1.sel, if1.entrada} !== 4'b100_1) begin
            n_err++;
            $display("FAIL mid_pre_reset got sel=%0d ent=%b want sel=4 ent=1", if1.sel, if1.entrada);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if ({if1.ready, if1.busy, if1.done, if1.sel, if1.entrada} !== 7'b1_0_0_000_0) begin
                n_err++;
                $display("FAIL mid_after_reset cyc=%0d got %b want 1000000", i,
                         {if1.ready, if1.busy, if1.done, if1.sel, if1.entrada});
            end
            tick();
        end
        w = 8'h3C;
        if1.dado = w; if1.valid = 1'b1;
        tick();
        if1.valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            n_vec++;
            if ({if1.sel, if1.entrada} !== {exp_sel(j), w[exp_sel(j)]}) begin
                n_err++;
                $display("FAIL mid_next_word k=%0d got sel=%0d ent=%b want sel=%0d ent=%b",
                         j, if1.sel, if1.entrada, exp_sel(j), w[exp_sel(j)]);
            end
            tick();
        end
        n_vec++;
        if ({if1.done, if1.sel} !== 4'b1_000) begin
            n_err++;
            $display("FAIL mid_next_done got done,sel=%b want 1000", {if1.done, if1.sel});
        end
        tick();
    endtask

`ifdef DMUX8WAY_SEQ_MSB_FIRST_EN
    task automatic test_msb_first();
        int h_cyc;
        int a_cyc;
        int ones;
        h_cyc = -1; a_cyc = -1; ones = 0;
        if1.dado = 8'b1000_0001; if1.valid = 1'b1;
        tick();
        if1.valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (outs1[7] && h_cyc < 0) h_cyc = k;
            if (outs1[0] && a_cyc < 0) a_cyc = k;
            ones += int'(if1.entrada);
            tick();
        end
        n_vec++;
        if (h_cyc !== 0 || a_cyc !== 7) begin
            n_err++;
            $display("FAIL msb_order got h=%0d a=%0d want h=0 a=7", h_cyc, a_cyc);
        end
        n_vec++;
        if (ones !== 2) begin
            n_err++;
            $display("FAIL msb_ones got %0d want 2", ones);
        end
        n_vec++;
        if ({if1.done, if1.sel} !== 4'b1_000) begin
            n_err++;
            $display("FAIL msb_done got done,sel=%b want 1000", {if1.done, if1.sel});
        end
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_reset_and_valid();
        test_basic();
        test_hold_stretch();
        test_back_to_back();
        test_reset_mid();
`ifdef DMUX8WAY_SEQ_MSB_FIRST_EN
        test_msb_first();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
